// File: rtl/riscv_pkg.sv
// Shared constants and enums for the core's memory-port arbitration logic.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } mem_owner_e;

endpackage

// File: rtl/mem_arb_timeout_cnt.sv
// Loadable up-counter with a terminal-count flag, used to bound memory response latency.
module mem_arb_timeout_cnt #(
  parameter int unsigned Width     = 6,
  parameter int unsigned TermCount = 63
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == Width'(TermCount));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access: arbitrates with a starvation
// guard, keeps one transaction outstanding, routes the response to its owner and times out.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [XLEN-1:0]   i_req_addr,
  output logic              i_rsp_valid,
  output logic [XLEN-1:0]   i_rsp_rdata,
  output logic              i_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [XLEN-1:0]   d_req_addr,
  input  logic              d_req_we,
  input  logic [XLEN/8-1:0] d_req_be,
  input  logic [XLEN-1:0]   d_req_wdata,
  output logic              d_rsp_valid,
  output logic [XLEN-1:0]   d_rsp_rdata,
  output logic              d_rsp_err,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [XLEN-1:0]   m_req_addr,
  output logic              m_req_we,
  output logic [XLEN/8-1:0] m_req_be,
  output logic [XLEN-1:0]   m_req_wdata,
  input  logic              m_rsp_valid,
  input  logic [XLEN-1:0]   m_rsp_rdata,
  input  logic              m_rsp_err
);

  localparam int unsigned BeW  = XLEN / 8;
  localparam int unsigned StW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_e       state_d, state_q;
  mem_owner_e       owner_d, owner_q;
  logic [StW-1:0]   starve_d, starve_q;
  logic [XLEN-1:0]  addr_d, addr_q;
  logic             we_d, we_q;
  logic [BeW-1:0]   be_d, be_q;
  logic [XLEN-1:0]  wdata_d, wdata_q;
  logic             starve_sat;
  logic             d_win;
  logic             tmo_load;
  logic             tmo_en;
  logic             tmo_tc;

  assign starve_sat = (starve_q == StW'(STARVE_LIMIT));
  // I only overrides D once it has been passed over STARVE_LIMIT times in a row.
  assign d_win      = d_req_valid && !(i_req_valid && starve_sat);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    tmo_load    = 1'b0;
    tmo_en      = 1'b0;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    m_req_valid = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_rdata = '0;
    i_rsp_err   = 1'b0;
    d_rsp_valid = 1'b0;
    d_rsp_rdata = '0;
    d_rsp_err   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_win) begin
          d_req_ready = 1'b1;
          addr_d      = d_req_addr;
          we_d        = d_req_we;
          be_d        = d_req_be;
          wdata_d     = d_req_wdata;
          owner_d     = OWN_D;
          state_d     = ISSUE;
          if (i_req_valid && !starve_sat) begin
            starve_d = starve_q + StW'(1);
          end
        end else if (i_req_valid) begin
          i_req_ready = 1'b1;
          addr_d      = i_req_addr;
          we_d        = 1'b0;
          be_d        = '1;
          wdata_d     = '0;
          owner_d     = OWN_I;
          starve_d    = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        m_req_valid = 1'b1;
        if (m_req_ready) begin
          tmo_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // A response in the terminal-count cycle still wins over the timeout.
        if (m_rsp_valid) begin
          if (owner_q == OWN_I) begin
            i_rsp_valid = 1'b1;
            i_rsp_rdata = m_rsp_rdata;
            i_rsp_err   = m_rsp_err;
          end else begin
            d_rsp_valid = 1'b1;
            d_rsp_rdata = m_rsp_rdata;
            d_rsp_err   = m_rsp_err;
          end
          state_d = IDLE;
        end else if (tmo_tc) begin
          if (owner_q == OWN_I) begin
            i_rsp_valid = 1'b1;
            i_rsp_err   = 1'b1;
          end else begin
            d_rsp_valid = 1'b1;
            d_rsp_err   = 1'b1;
          end
          state_d = DRAIN;
        end else begin
          tmo_en = 1'b1;
        end
      end
      DRAIN: begin
        if (m_rsp_valid) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      starve_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

  assign m_req_addr  = addr_q;
  assign m_req_we    = we_q;
  assign m_req_be    = be_q;
  assign m_req_wdata = wdata_q;

  mem_arb_timeout_cnt #(
    .Width     (TmoW),
    .TermCount (TIMEOUT_CYCLES - 1)
  ) u_tmo_cnt (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .load_i     (tmo_load),
    .load_val_i ('0),
    .en_i       (tmo_en),
    .tc_o       (tmo_tc)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory with programmable latency/back-pressure,
// expected responses queued at each grant and checked when the arbiter delivers them.
module tb_mem_port_arbiter;
  import riscv_pkg::*;

  localparam int unsigned STARVE = 4;
  localparam int unsigned TMO    = 64;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              i_req_valid, i_req_ready;
  logic [XLEN-1:0]   i_req_addr;
  logic              i_rsp_valid, i_rsp_err;
  logic [XLEN-1:0]   i_rsp_rdata;
  logic              d_req_valid, d_req_ready, d_req_we;
  logic [XLEN-1:0]   d_req_addr, d_req_wdata;
  logic [XLEN/8-1:0] d_req_be;
  logic              d_rsp_valid, d_rsp_err;
  logic [XLEN-1:0]   d_rsp_rdata;
  logic              m_req_valid, m_req_ready, m_req_we;
  logic [XLEN-1:0]   m_req_addr, m_req_wdata;
  logic [XLEN/8-1:0] m_req_be;
  logic              m_rsp_valid, m_rsp_err;
  logic [XLEN-1:0]   m_rsp_rdata;

  mem_port_arbiter #(
    .STARVE_LIMIT   (STARVE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_rdata (i_rsp_rdata),
    .i_rsp_err   (i_rsp_err),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_addr  (d_req_addr),
    .d_req_we    (d_req_we),
    .d_req_be    (d_req_be),
    .d_req_wdata (d_req_wdata),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_rdata (d_rsp_rdata),
    .d_rsp_err   (d_rsp_err),
    .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready),
    .m_req_addr  (m_req_addr),
    .m_req_we    (m_req_we),
    .m_req_be    (m_req_be),
    .m_req_wdata (m_req_wdata),
    .m_rsp_valid (m_rsp_valid),
    .m_rsp_rdata (m_rsp_rdata),
    .m_rsp_err   (m_rsp_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic            is_d;
    logic [XLEN-1:0] rdata;
    logic            err;
    int              lat;
  } exp_t;

  exp_t exp_q[$];
  logic grant_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   mem_lat = 0;
  logic mem_err = 1'b0;
  int   bp_seq  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] mem_data(input logic [XLEN-1:0] a);
    return a ^ 32'h0000_0113;
  endfunction

  // Behavioural memory: responds mem_lat cycles after the cycle following a handshake.
  initial begin : mem_model
    logic            hs;
    logic            pend;
    int              cnt;
    int              hold;
    int              bp_last;
    logic [XLEN-1:0] a;
    logic            e;
    m_req_ready = 1'b1;
    m_rsp_valid = 1'b0;
    m_rsp_rdata = 32'hDEAD_BEEF;
    m_rsp_err   = 1'b0;
    pend = 1'b0; cnt = 0; hold = 0; bp_last = 0; a = '0; e = 1'b0;
    forever begin
      @(negedge CLK);
      hs = m_req_valid && m_req_ready;
      if (hs) a = m_req_addr;
      @(posedge CLK);
      #1;
      m_rsp_valid = 1'b0;
      m_rsp_rdata = 32'hDEAD_BEEF;
      m_rsp_err   = 1'b1;
      if (bp_seq != bp_last) begin
        bp_last = bp_seq;
        hold    = 5;
      end
      if (hold > 0) begin
        m_req_ready = 1'b0;
        hold--;
      end else begin
        m_req_ready = 1'b1;
      end
      if (hs) begin
        pend = 1'b1;
        cnt  = mem_lat;
        e    = mem_err;
      end
      if (pend) begin
        if (cnt == 0) begin
          m_rsp_valid = 1'b1;
          m_rsp_rdata = mem_data(a);
          m_rsp_err   = e;
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: pushes expectations at each grant, checks the issued request and every response.
  initial begin : monitor
    exp_t            e;
    logic [XLEN-1:0] er_addr, er_wdata;
    logic            er_we;
    logic [3:0]      er_be;
    int              hs_cyc;
    logic            tmo;
    logic [XLEN-1:0] ga;
    er_addr = '0; er_wdata = '0; er_we = 1'b0; er_be = '0; hs_cyc = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RESET) begin
        if (i_req_ready || d_req_ready) begin
          check_eq("one_ready", {i_req_ready, d_req_ready}, d_req_ready ? 2'b01 : 2'b10);
          tmo    = (mem_lat + 1) > TMO;
          e.is_d = d_req_ready;
          ga     = d_req_ready ? d_req_addr : i_req_addr;
          e.rdata = tmo ? '0 : mem_data(ga);
          e.err   = tmo ? 1'b1 : mem_err;
          e.lat   = tmo ? TMO : mem_lat + 1;
          exp_q.push_back(e);
          grant_log.push_back(d_req_ready);
          er_addr  = ga;
          er_we    = d_req_ready ? d_req_we : 1'b0;
          er_be    = d_req_ready ? d_req_be : 4'hF;
          er_wdata = d_req_ready ? d_req_wdata : '0;
        end
        if (m_req_valid && m_req_ready) begin
          check_eq("hs_addr", m_req_addr, er_addr);
          check_eq("hs_we", m_req_we, er_we);
          check_eq("hs_be", m_req_be, er_be);
          if (er_we) check_eq("hs_wdata", m_req_wdata, er_wdata);
          hs_cyc = cyc;
        end
        if (i_rsp_valid || d_rsp_valid) begin
          if (exp_q.size() == 0) begin
            check_eq("rsp_unexpected", {i_rsp_valid, d_rsp_valid}, 2'b00);
          end else begin
            e = exp_q.pop_front();
            check_eq("rsp_owner", {i_rsp_valid, d_rsp_valid}, e.is_d ? 2'b01 : 2'b10);
            check_eq("rsp_rdata", d_rsp_valid ? d_rsp_rdata : i_rsp_rdata, e.rdata);
            check_eq("rsp_err", d_rsp_valid ? d_rsp_err : i_rsp_err, e.err);
            check_eq("rsp_lat", cyc - hs_cyc, e.lat);
          end
        end
      end
    end
  end

  task automatic issue(input logic is_d, input logic [XLEN-1:0] addr, input logic we,
                       input logic [3:0] be, input logic [XLEN-1:0] wdata);
    logic ok;
    @(posedge CLK);
    #2;
    if (is_d) begin
      d_req_valid = 1'b1; d_req_addr = addr; d_req_we = we; d_req_be = be; d_req_wdata = wdata;
    end else begin
      i_req_valid = 1'b1; i_req_addr = addr;
    end
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (is_d ? d_req_ready : i_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("grant_wait", is_d ? d_req_ready : i_req_ready, 1'b1);
    @(posedge CLK);
    #2;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge CLK);
      #1;
    end
    check_eq("sb_drain", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin : main
    int               gap;
    logic [9:0]       pat;
    logic             t_d  [4];
    logic [XLEN-1:0]  t_a  [4];
    logic             t_we [4];
    int               t_lat[4];
    logic             t_err[4];

    RESET = 1'b0;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_be = '0; d_req_wdata = '0;
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b1;

    // Reset state
    @(negedge CLK);
    check_eq("rst_ctrl", {m_req_valid, i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid,
                          i_rsp_err, d_rsp_err, m_req_we}, 8'h00);
    check_eq("rst_i_rdata", i_rsp_rdata, 0);
    check_eq("rst_d_rdata", d_rsp_rdata, 0);
    check_eq("rst_m_addr", m_req_addr, 0);
    check_eq("rst_m_be", m_req_be, 0);

    // I-only read
    mem_lat = 0; mem_err = 1'b0;
    issue(1'b0, 32'h100, 1'b0, 4'h0, '0);
    @(negedge CLK);
    check_eq("ionly_m_valid", m_req_valid, 1'b1);
    check_eq("ionly_m_addr", m_req_addr, 32'h100);
    check_eq("ionly_m_we", m_req_we, 1'b0);
    check_eq("ionly_m_be", m_req_be, 4'hF);
    @(negedge CLK);
    check_eq("ionly_rsp_valid", i_rsp_valid, 1'b1);
    check_eq("ionly_rsp_rdata", i_rsp_rdata, 32'h0000_0013);
    check_eq("ionly_d_quiet", d_rsp_valid, 1'b0);
    wait_idle();

    // Simultaneous I and D: D first, I on the next IDLE three cycles later
    @(posedge CLK);
    #2;
    i_req_valid = 1'b1; i_req_addr = 32'h140;
    d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_we = 1'b1; d_req_be = 4'h3;
    d_req_wdata = 32'h0000_BEEF;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (d_req_ready) break;
    end
    check_eq("sim_d_ready", d_req_ready, 1'b1);
    check_eq("sim_i_held", i_req_ready, 1'b0);
    @(posedge CLK);
    #2 d_req_valid = 1'b0;
    gap = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (i_req_ready) break;
      gap++;
    end
    check_eq("sim_i_gap", gap, 3);
    @(posedge CLK);
    #2 i_req_valid = 1'b0;
    wait_idle();

    // Starvation guard with both requesters held high
    grant_log.delete();
    @(posedge CLK);
    #2;
    i_req_valid = 1'b1; i_req_addr = 32'h400;
    d_req_valid = 1'b1; d_req_addr = 32'h500; d_req_we = 1'b0; d_req_be = 4'hF;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      #1;
      if (grant_log.size() >= 10) break;
    end
    @(posedge CLK);
    #2;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    check_eq("starve_grants", grant_log.size(), 10);
    pat = 10'b01111_01111;
    for (int k = 0; k < 10 && k < grant_log.size(); k++) begin
      check_eq($sformatf("starve_g%0d", k), grant_log[k], pat[k]);
    end
    wait_idle();

    // Latency/error mix including a response landing on the timeout cycle
    t_d[0] = 1'b1; t_a[0] = 32'h600; t_we[0] = 1'b0; t_lat[0] = 2;       t_err[0] = 1'b1;
    t_d[1] = 1'b0; t_a[1] = 32'h104; t_we[1] = 1'b0; t_lat[1] = 3;       t_err[1] = 1'b0;
    t_d[2] = 1'b1; t_a[2] = 32'h604; t_we[2] = 1'b1; t_lat[2] = 1;       t_err[2] = 1'b0;
    t_d[3] = 1'b0; t_a[3] = 32'h108; t_we[3] = 1'b0; t_lat[3] = TMO - 1; t_err[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_lat = t_lat[k];
      mem_err = t_err[k];
      issue(t_d[k], t_a[k], t_we[k], 4'hC, 32'h1234_0000 + k);
      wait_idle();
    end
    mem_err = 1'b0;

    // Timeout: late response must be swallowed, next request normal
    mem_lat = TMO + 6;
    issue(1'b1, 32'h300, 1'b0, 4'hF, '0);
    wait_idle();
    repeat (12) @(negedge CLK);
    mem_lat = 0;
    issue(1'b0, 32'h10C, 1'b0, 4'h0, '0);
    wait_idle();

    // Back-pressure: m_req_ready low for 5 cycles while I keeps requesting
    @(posedge CLK);
    #2;
    bp_seq++;
    i_req_valid = 1'b1; i_req_addr = 32'h110;
    d_req_valid = 1'b1; d_req_addr = 32'h700; d_req_we = 1'b0; d_req_be = 4'hF;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (d_req_ready) break;
    end
    @(posedge CLK);
    #2 d_req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check_eq($sformatf("bp_valid%0d", k), m_req_valid, 1'b1);
      check_eq($sformatf("bp_addr%0d", k), m_req_addr, 32'h700);
      check_eq($sformatf("bp_ready%0d", k), {i_req_ready, d_req_ready}, 2'b00);
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (i_req_ready) break;
    end
    check_eq("bp_i_grant", i_req_ready, 1'b1);
    @(posedge CLK);
    #2 i_req_valid = 1'b0;
    wait_idle();

    // Reset while waiting for a response
    mem_lat = 5;
    issue(1'b0, 32'h180, 1'b0, 4'h0, '0);
    @(negedge CLK);
    @(negedge CLK);
    #1 RESET = 1'b0;
    #1;
    check_eq("rstw_ctrl", {m_req_valid, i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid,
                           i_rsp_err, d_rsp_err}, 7'h00);
    check_eq("rstw_addr", m_req_addr, 0);
    check_eq("rstw_rdata", {i_rsp_rdata, d_rsp_rdata}, 0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b1;
    repeat (10) @(negedge CLK);
    mem_lat = 0;
    issue(1'b1, 32'h204, 1'b0, 4'hF, '0);
    wait_idle();

    repeat (3) @(negedge CLK);
    check_eq("final_sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
